// File: rtl/des_pkg.sv
// DES constant tables, bit-permutation helpers and the sequencer state type.
// Table entries use FIPS 46-3 numbering (1 = MSB). Bit n of a DES word sits
// at vector index (width + 1 - n), so the MSB is always the highest index.
package des_pkg;

    localparam int ROUNDS = 16;
    localparam int SLOTS  = 4;
    localparam int SLOT_W = $clog2(SLOTS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Each box is stored row-major: entry index = {row, col} = {b1, b6, b2..b5}.
    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
           0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
           4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
           3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
           0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
           1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{ 7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
           3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{ 2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
           4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
           9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
           4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{ 4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
           1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
           6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
           1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
           7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
           2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [64:1] ip_perm(input logic [64:1] x);
        logic [64:1] y;
        for (int i = 1; i <= 64; i++) y[65-i] = x[65-IP_T[i-1]];
        return y;
    endfunction

    function automatic logic [64:1] fp_perm(input logic [64:1] x);
        logic [64:1] y;
        for (int i = 1; i <= 64; i++) y[65-i] = x[65-FP_T[i-1]];
        return y;
    endfunction

    // Drops the eight key parity bits.
    function automatic logic [56:1] pc1_perm(input logic [64:1] x);
        logic [56:1] y;
        for (int i = 1; i <= 56; i++) y[57-i] = x[65-PC1_T[i-1]];
        return y;
    endfunction

    function automatic logic [48:1] pc2_perm(input logic [56:1] x);
        logic [48:1] y;
        for (int i = 1; i <= 48; i++) y[49-i] = x[57-PC2_T[i-1]];
        return y;
    endfunction

    function automatic logic [48:1] e_perm(input logic [32:1] x);
        logic [48:1] y;
        for (int i = 1; i <= 48; i++) y[49-i] = x[33-E_T[i-1]];
        return y;
    endfunction

    function automatic logic [32:1] p_perm(input logic [32:1] x);
        logic [32:1] y;
        for (int i = 1; i <= 32; i++) y[33-i] = x[33-P_T[i-1]];
        return y;
    endfunction

    function automatic logic [32:1] sbox_sub(input logic [48:1] x);
        logic [32:1] y;
        logic [5:0]  b;
        for (int j = 0; j < 8; j++) begin
            b = x[48-6*j -: 6];
            y[32-4*j -: 4] = 4'(SBOX[j][{b[5], b[0], b[4:1]}]);
        end
        return y;
    endfunction

endpackage

// File: rtl/des_round.sv
// One DES round: key-schedule rotation, subkey selection and Feistel update.
// Purely combinational; the caller registers every output.
module des_round
    import des_pkg::*;
(
    input  logic [32:1] l,
    input  logic [32:1] r,
    input  logic [28:1] c,
    input  logic [28:1] d,
    input  logic [1:0]  shift,
    output logic [32:1] l_next,
    output logic [32:1] r_next,
    output logic [28:1] c_next,
    output logic [28:1] d_next
);

    logic [48:1] subkey;

    // Rotate the key halves, derive this round's subkey, apply F to R.
    always_comb begin
        c_next = (shift == 2'd2) ? {c[26:1], c[28:27]} : {c[27:1], c[28]};
        d_next = (shift == 2'd2) ? {d[26:1], d[28:27]} : {d[27:1], d[28]};
        subkey = pc2_perm({c_next, d_next});
        l_next = r;
        r_next = l ^ p_perm(sbox_sub(e_perm(r) ^ subkey));
    end

endmodule

// File: rtl/des_tdm_top.sv
// Iterative DES core (one round per clock) with a four-slot TDM output port
// that shows the masked ciphertext only in slot 3 and decoy words otherwise.
//
// state | meaning
// IDLE  | waiting for CHIP_SELECT_BAR low; loads IP(plaintext), PC1(key)
// RUN   | one Feistel round per clock, rounds 1..16
// DONE  | register FP({R16, L16}) into CIPHER_TEXT, return to IDLE
module des_tdm_top
    import des_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        CHIP_SELECT_BAR,
    input  logic [64:1] PLAIN_TEXT,
    input  logic [64:1] KEY,
    input  logic [64:1] d,
    input  logic [64:1] s1,
    input  logic [64:1] s0,
    input  logic [64:1] f,
    output logic [64:1] CIPHER_TEXT,
    output logic [64:1] out
);

    state_t            state_q, state_d;
    logic [4:0]        round_q;
    logic [SLOT_W-1:0] slot_q;
    logic [32:1]       l_q, r_q, l_nx, r_nx;
    logic [28:1]       c_q, d_q, c_nx, d_nx;
    logic [64:1]       ip_out;
    logic [56:1]       pc1_out;
    logic [3:0]        round_idx;
    logic [1:0]        shift;
    logic              load, step, finish;

    assign ip_out    = ip_perm(PLAIN_TEXT);
    assign pc1_out   = pc1_perm(KEY);
    // Round 16 wraps the 4-bit index to 15, so no special case is needed.
    assign round_idx = round_q[3:0] - 4'd1;
    assign shift     = 2'(SHIFT_T[round_idx]);

    des_round u_round (
        .l      (l_q),
        .r      (r_q),
        .c      (c_q),
        .d      (d_q),
        .shift  (shift),
        .l_next (l_nx),
        .r_next (r_nx),
        .c_next (c_nx),
        .d_next (d_nx)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!CHIP_SELECT_BAR) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (round_q == 5'(ROUNDS)) state_d = DONE;
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Cipher datapath: load, iterate, then publish with the halves swapped.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            round_q     <= '0;
            CIPHER_TEXT <= '0;
        end else if (load) begin
            l_q     <= ip_out[64:33];
            r_q     <= ip_out[32:1];
            c_q     <= pc1_out[56:29];
            d_q     <= pc1_out[28:1];
            round_q <= 5'd1;
        end else if (step) begin
            l_q     <= l_nx;
            r_q     <= r_nx;
            c_q     <= c_nx;
            d_q     <= d_nx;
            round_q <= round_q + 5'd1;
        end else if (finish) begin
            CIPHER_TEXT <= fp_perm({r_q, l_q});
            round_q     <= '0;
        end
    end

    // Free-running slot counter and registered TDM output mux.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            slot_q <= '0;
            out    <= '0;
        end else begin
            slot_q <= slot_q + 1'b1;
            case (slot_q)
                2'd0:    out <= d;
                2'd1:    out <= s1;
                2'd2:    out <= s0;
                default: out <= CIPHER_TEXT ^ f;
            endcase
        end
    end

endmodule

// File: tb/tb_des_tdm_top.sv
// Directed bench for des_tdm_top. Expected ciphertexts are queued with the
// edge on which they must appear; out is predicted every edge from a slot model.
module tb_des_tdm_top;

    logic        CLK, RST, CHIP_SELECT_BAR;
    logic [64:1] PLAIN_TEXT, KEY, d, s1, s0, f;
    logic [64:1] CIPHER_TEXT, out;

    typedef struct {
        logic [64:1] ct;
        int          due;
    } sb_t;

    sb_t         sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int          edge_cnt = 0;
    logic [1:0]  slot_m   = 2'd0;
    logic [64:1] ct_exp   = '0;

    localparam logic [64:1] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [64:1] KAT_PT  = 64'h0123456789ABCDEF;
    localparam logic [64:1] KAT_CT  = 64'h85E813540F0AB405;
    localparam logic [64:1] KAT_TDM = 64'h7A17ECABF0F54BFA;
    localparam logic [64:1] WK_KEY  = 64'h0101010101010101;
    localparam logic [64:1] WK_PT   = 64'h8000000000000000;
    localparam logic [64:1] WK_CT   = 64'h95F8A5E5DD31D900;
    localparam logic [64:1] ONES    = 64'hFFFFFFFFFFFFFFFF;

    des_tdm_top dut (
        .CLK             (CLK),
        .RST             (RST),
        .CHIP_SELECT_BAR (CHIP_SELECT_BAR),
        .PLAIN_TEXT      (PLAIN_TEXT),
        .KEY             (KEY),
        .d               (d),
        .s1              (s1),
        .s0              (s0),
        .f               (f),
        .CIPHER_TEXT     (CIPHER_TEXT),
        .out             (out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [64:1] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [64:1] obs, input logic [64:1] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_ct(input logic [64:1] ct, input int due);
        sb_t e;
        e.ct  = ct;
        e.due = due;
        sb.push_back(e);
    endtask

    // Fresh decoys, one clock edge, then check both outputs against the model.
    task automatic step();
        logic [64:1] exp_out;
        logic [64:1] ct_pre;
        logic [1:0]  slot_pre;
        d  = rnd64();
        s1 = rnd64();
        s0 = rnd64();
        ct_pre   = ct_exp;
        slot_pre = slot_m;
        if (!RST) exp_out = '0;
        else begin
            case (slot_m)
                2'd0:    exp_out = d;
                2'd1:    exp_out = s1;
                2'd2:    exp_out = s0;
                default: exp_out = ct_exp ^ f;
            endcase
        end
        @(posedge CLK);
        #1;
        edge_cnt++;
        if (!RST) begin
            slot_m = 2'd0;
            ct_exp = '0;
        end else begin
            slot_m = slot_m + 2'd1;
            if (sb.size() > 0 && sb[0].due == edge_cnt) ct_exp = sb.pop_front().ct;
        end
        check("cipher_text", CIPHER_TEXT, ct_exp);
        check("out", out, exp_out);
        if (RST && slot_pre == 2'd3 && f == ONES && ct_pre == KAT_CT)
            check("tdm_slot3_kat", out, KAT_TDM);
    endtask

    // Start edge with the given operands, then scramble them mid-run.
    task automatic start(input logic [64:1] pt, input logic [64:1] key, input logic [64:1] ct);
        CHIP_SELECT_BAR = 1'b0;
        PLAIN_TEXT      = pt;
        KEY             = key;
        expect_ct(ct, edge_cnt + 18);
        step();
        CHIP_SELECT_BAR = 1'b1;
        PLAIN_TEXT      = rnd64();
        KEY             = rnd64();
    endtask

    initial begin
        RST             = 1'b0;
        CHIP_SELECT_BAR = 1'b1;
        PLAIN_TEXT      = '0;
        KEY             = '0;
        d               = '0;
        s1              = '0;
        s0              = '0;
        f               = 64'h0F1E2D3C4B5A6978;

        // Held in reset with the clock running, even with chip select low.
        CHIP_SELECT_BAR = 1'b0;
        repeat (3) step();
        CHIP_SELECT_BAR = 1'b1;

        // Release: slots 0..3 show d, s1, s0, then 0 ^ f.
        RST = 1'b1;
        repeat (4) step();

        // Known answer.
        start(KAT_PT, KAT_KEY, KAT_CT);
        repeat (17) step();

        // TDM with an all-ones mask: slot 3 shows the inverted ciphertext.
        f = ONES;
        repeat (8) step();
        f = 64'h0123456789ABCDEF;

        // Weak key encrypts to the value that encrypts back to the plaintext.
        start(WK_PT, WK_KEY, WK_CT);
        repeat (17) step();
        start(WK_CT, WK_KEY, WK_PT);
        repeat (17) step();

        // Chip select high in IDLE: nothing starts, ciphertext holds.
        PLAIN_TEXT = KAT_PT;
        KEY        = KAT_KEY;
        repeat (20) step();

        // Back-to-back with chip select held low; operands swap mid-run.
        CHIP_SELECT_BAR = 1'b0;
        PLAIN_TEXT      = KAT_PT;
        KEY             = KAT_KEY;
        expect_ct(KAT_CT, edge_cnt + 18);
        step();
        PLAIN_TEXT = WK_PT;
        KEY        = WK_KEY;
        repeat (17) step();
        expect_ct(WK_CT, edge_cnt + 18);
        step();
        CHIP_SELECT_BAR = 1'b1;
        PLAIN_TEXT      = rnd64();
        KEY             = rnd64();
        repeat (17) step();
        repeat (2) step();

        // Abort around round 8: outputs clear at once, no partial result.
        start(KAT_PT, KAT_KEY, KAT_CT);
        repeat (7) step();
        RST = 1'b0;
        #1;
        sb.delete();
        ct_exp = '0;
        slot_m = 2'd0;
        check("abort_cipher_text", CIPHER_TEXT, '0);
        check("abort_out", out, '0);
        repeat (2) step();
        RST = 1'b1;

        // Recovery after abort.
        start(KAT_PT, KAT_KEY, KAT_CT);
        repeat (17) step();
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_tdm_top.md
Name:
des_tdm_top

Overview:
- Iterative DES encryption core: 64-bit block, 64-bit key, one Feistel round per clock.
- Adds a time-division-multiplexed (TDM) output port `out`, a countermeasure against data-leakage trojans.
  - The masked ciphertext appears on `out` only in one of four rotating time slots.
  - Decoy words fill the other three slots.
- Sits at chip top level, between host input registers and the output pads.

Parameters:
- ROUNDS, 16, number of DES rounds. Fixed; only 16 is supported.
- SLOTS, 4, TDM slot count. Fixed; implemented as a 2-bit counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset (0 = reset asserted).
- CHIP_SELECT_BAR  input  1  active-low enable; 0 lets the core start an encryption.
- PLAIN_TEXT  input  64 [64:1]  plaintext block.
- KEY  input  64 [64:1]  DES key, including 8 parity bits, which are ignored.
- d  input  64 [64:1]  decoy word driven on `out` in slot 0.
- s1  input  64 [64:1]  decoy word driven on `out` in slot 1.
- s0  input  64 [64:1]  decoy word driven on `out` in slot 2.
- f  input  64 [64:1]  XOR mask applied to the ciphertext in slot 3.
- CIPHER_TEXT  output  64 [64:1]  registered DES ciphertext.
- out  output  64 [64:1]  registered TDM output.

Behaviour:
- Reset:
  - One clock (CLK); reset RST is asynchronous, active-low.
  - While RST=0: CIPHER_TEXT=0, out=0, round counter=0, slot counter=0, state=IDLE, L/R/C/D registers=0.
  - Reset asserted mid-operation aborts the operation immediately; no partial result is ever shown.
- Bit order: DES bit n (FIPS 46-3 numbering, 1 = MSB) maps to vector index 65-n, so index 64 is the MSB.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On a rising edge with CHIP_SELECT_BAR=0, load {L0,R0}=IP(PLAIN_TEXT) and {C0,D0}=PC1(KEY).
  - Set round=1 and go to RUN.
  - If CHIP_SELECT_BAR=1, stay in IDLE.
- RUN:
  - Each clock, rotate C and D left by the schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Compute Ki=PC2(C,D).
  - Update L<=R and R<=L^F(R,Ki), where F = P(Sboxes(E(R)^Ki)).
  - After round 16, go to DONE.
  - CHIP_SELECT_BAR is ignored once RUN has been entered.
- DONE:
  - CIPHER_TEXT <= FP({R16,L16}), i.e. swapped halves.
  - Go to IDLE.
- Latency: 18 rising edges from the start edge to CIPHER_TEXT valid (1 load + 16 rounds + 1 output).
- CIPHER_TEXT holds its value until the next DONE.
- Back-to-back operation: if CHIP_SELECT_BAR stays low, a new encryption starts on the edge after DONE, giving 18-cycle throughput.
- PLAIN_TEXT and KEY are sampled only on the start edge; later changes to them do not affect an operation in progress.
- TDM slot counter:
  - 2-bit, free-running, increments every clock after reset release and wraps 3->0.
  - out is registered: on each edge, out <= slot 0: d; slot 1: s1; slot 2: s0; slot 3: CIPHER_TEXT^f, using the current CIPHER_TEXT register.
  - The slot counter is independent of CHIP_SELECT_BAR and of the DES FSM.
- Decoy inputs are sampled every cycle; no holding is required.

Decomposition:
- Package des_pkg holds the DES constant tables: IP, FP, E, P, PC1, PC2, the 16-entry shift schedule, and the 8 S-boxes (4x16 each).
- Package des_pkg also holds the FSM state enum {IDLE, RUN, DONE}.
- One sub-module, des_round: purely combinational F-function plus key-schedule step.
  - Inputs: L, R, C, D, shift amount.
  - Outputs: next L, R, C, D.
- The top holds the FSM, round/slot counters, IP/FP/PC1 wiring and the TDM mux.

Test Plan:
- Reset: RST=0 with CLK running -> CIPHER_TEXT=0 and out=0 throughout. Release RST=1 -> out sequence starts with d, s1, s0, then 0^f on consecutive edges.
- Known answer: KEY=133457799BBCDFF1, PLAIN_TEXT=0123456789ABCDEF, CHIP_SELECT_BAR=0 -> CIPHER_TEXT=85E813540F0AB405 exactly 18 edges after start.
- Weak key: KEY=0101010101010101, PLAIN_TEXT=8000000000000000 -> 95F8A5E5DD31D900. Then PLAIN_TEXT=95F8A5E5DD31D900 -> 8000000000000000.
- TDM: f=FFFFFFFFFFFFFFFF with CIPHER_TEXT=85E813540F0AB405 -> out=7A17ECABF0F54BFA in slot 3 only. d, s1, s0 appear verbatim in slots 0-2, and the pattern repeats every 4 clocks.
- Chip select: CHIP_SELECT_BAR=1 in IDLE -> no start, CIPHER_TEXT unchanged. Changing PLAIN_TEXT/KEY mid-RUN -> the result still matches the values sampled at start.
- Abort: assert RST=0 at round 8 -> all outputs 0 immediately. After release, a new encryption gives the correct known-answer result.
